// File: rtl/tqvp_dsatizabal_fpu_seq.sv
// tqvp_dsatizabal_fpu_seq: multi-cycle binary32 add/sub/mul peripheral
// with an iterative multiplier, status flags and completion interrupt.
module tqvp_dsatizabal_fpu_seq #(
  parameter int MUL_STEP   = 4,
  parameter bit IRQ_EN_RST = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);
  localparam int ITERS = 24 / MUL_STEP;
  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, NORM} state_t;

  state_t state, state_nx;
  logic [31:0] a_q, b_q, result_q;
  logic [1:0]  op_q;
  logic        irq_en_q, done_q, inv_q, ovf_q, zero_q, sign_q;
  logic signed [11:0] exp_q;
  logic [47:0] mag_q;
  logic [CW-1:0] cnt_q;

  logic busy, wr, ctrl_wr, start, rd_res, last_iter, is_mul;
  assign busy      = state != IDLE;
  assign wr        = data_write_n == 2'b10;
  assign ctrl_wr   = wr && address == 6'h08 && !busy;
  assign start     = ctrl_wr && data_in[1:0] != OP_RSV;
  assign rd_res    = data_read_n != 2'b11 && address == 6'h0C;
  assign last_iter = cnt_q == CW'(ITERS - 1);
  assign is_mul    = op_q == OP_MUL;

  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [23:0] siga, sigb;
  logic a_inf, b_inf, a_nan, b_nan, a_zero, b_zero;
  assign sa     = a_q[31];
  assign sb     = b_q[31] ^ (op_q == OP_SUB);
  assign ea     = a_q[30:23];
  assign eb     = b_q[30:23];
  assign a_zero = ea == 8'h00;
  assign b_zero = eb == 8'h00;
  assign a_inf  = ea == 8'hFF && a_q[22:0] == '0;
  assign b_inf  = eb == 8'hFF && b_q[22:0] == '0;
  assign a_nan  = ea == 8'hFF && a_q[22:0] != '0;
  assign b_nan  = eb == 8'hFF && b_q[22:0] != '0;
  assign siga   = a_zero ? 24'd0 : {1'b1, a_q[22:0]};
  assign sigb   = b_zero ? 24'd0 : {1'b1, b_q[22:0]};

  logic        a_big, eff_sub;
  logic [7:0]  big_e, diff;
  logic [23:0] big_m, sml_m, sml_sh;
  logic [24:0] sum;
  always_comb begin
    a_big   = {ea, siga} >= {eb, sigb};
    big_e   = a_big ? ea : eb;
    diff    = a_big ? ea - eb : eb - ea;
    big_m   = a_big ? siga : sigb;
    sml_m   = a_big ? sigb : siga;
    sml_sh  = (diff >= 8'd24) ? 24'd0 : sml_m >> diff;
    eff_sub = sa ^ sb;
    sum     = eff_sub ? {1'b0, big_m} - {1'b0, sml_sh}
                      : {1'b0, big_m} + {1'b0, sml_sh};
  end

  // Low half of mag_q holds the unconsumed multiplier bits.
  logic [MUL_STEP-1:0]  chunk;
  logic [23+MUL_STEP:0] hi_sum;
  logic [47+MUL_STEP:0] mul_t;
  assign chunk  = mag_q[MUL_STEP-1:0];
  assign hi_sum = {{MUL_STEP{1'b0}}, mag_q[47:24]}
                + ({{MUL_STEP{1'b0}}, siga} * {24'b0, chunk});
  assign mul_t  = {hi_sum, mag_q[23:0]};

  logic [5:0]  lead;
  logic [47:0] norm_sh;
  logic signed [11:0] exp_n;
  logic [31:0] res_pk;
  logic res_inv, res_ovf, spec_nan, spec_inf, spec_sign;
  always_comb begin
    lead = '0;
    for (int i = 0; i < 48; i++)
      if (mag_q[i]) lead = 6'(i);
    norm_sh   = mag_q << (6'd47 - lead);
    exp_n     = exp_q + $signed({6'b0, lead}) - 12'sd46;
    spec_nan  = a_nan | b_nan | (is_mul
              ? (a_inf & b_zero) | (a_zero & b_inf)
              : a_inf & b_inf & eff_sub);
    spec_inf  = a_inf | b_inf;
    spec_sign = is_mul ? sign_q : (a_inf ? sa : sb);
    res_inv   = 1'b0;
    res_ovf   = 1'b0;
    if (spec_nan) begin
      res_pk  = 32'h7FC0_0000;
      res_inv = 1'b1;
    end else if (spec_inf) begin
      res_pk  = {spec_sign, 8'hFF, 23'h0};
    end else if (mag_q == '0 || exp_n <= 12'sd0) begin
      res_pk  = {is_mul & sign_q, 31'h0};
    end else if (exp_n >= 12'sd255) begin
      res_pk  = {sign_q, 8'hFF, 23'h0};
      res_ovf = 1'b1;
    end else begin
      res_pk  = {sign_q, exp_n[7:0], norm_sh[46:24]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = EXEC;
      EXEC:    if (!is_mul || last_iter) state_nx = NORM;
      NORM:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      op_q     <= '0;
      irq_en_q <= IRQ_EN_RST;
      done_q   <= 1'b0;
      inv_q    <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mag_q    <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr && !busy && address == 6'h00) a_q <= data_in;
      if (wr && !busy && address == 6'h04) b_q <= data_in;
      if (ctrl_wr) irq_en_q <= data_in[2];
      if (start) begin
        op_q   <= data_in[1:0];
        done_q <= 1'b0;
        inv_q  <= 1'b0;
        ovf_q  <= 1'b0;
        zero_q <= 1'b0;
        cnt_q  <= '0;
        mag_q  <= {24'b0, sigb};
        exp_q  <= $signed({4'b0, ea}) + $signed({4'b0, eb}) - 12'sd127;
        sign_q <= a_q[31] ^ b_q[31];
      end else if (rd_res) begin
        done_q <= 1'b0;
      end
      // Completion is last so it wins over a same-cycle result read.
      unique case (state)
        EXEC: begin
          if (is_mul) begin
            mag_q <= mul_t[47+MUL_STEP:MUL_STEP];
            cnt_q <= cnt_q + CW'(1);
          end else begin
            mag_q  <= {sum, 23'b0};
            exp_q  <= $signed({4'b0, big_e});
            sign_q <= a_big ? sa : sb;
          end
        end
        NORM: begin
          result_q <= res_pk;
          done_q   <= 1'b1;
          inv_q    <= res_inv;
          ovf_q    <= res_ovf;
          zero_q   <= res_pk[30:0] == '0;
        end
        default: ;
      endcase
    end
  end

  assign uo_out         = {6'b0, done_q, busy};
  assign data_ready     = 1'b1;
  assign user_interrupt = done_q & irq_en_q;

  always_comb begin
    data_out = '0;
    unique case (address)
      6'h00:   data_out = a_q;
      6'h04:   data_out = b_q;
      6'h08:   data_out = {29'b0, irq_en_q, op_q};
      6'h0C:   data_out = result_q;
      6'h10:   data_out = {27'b0, zero_q, ovf_q, inv_q, done_q, busy};
      default: data_out = '0;
    endcase
  end

  logic unused_ok;
  assign unused_ok = ^{ui_in, norm_sh[47], norm_sh[23:0],
                       mul_t[MUL_STEP-1:0]};
endmodule

// File: tb/tb_tqvp_dsatizabal_fpu_seq.sv
// tb_tqvp_dsatizabal_fpu_seq: directed and random checks of the
// sequential FPU against an arithmetic reference model.
module tb_tqvp_dsatizabal_fpu_seq;
  localparam int K = 24 / 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_res = '0;

  always #5 clk = ~clk;

  tqvp_dsatizabal_fpu_seq dut (
    .clk(clk),
    .rst_n(rst_n),
    .ui_in(ui_in),
    .uo_out(uo_out),
    .address(address),
    .data_in(data_in),
    .data_write_n(data_write_n),
    .data_read_n(data_read_n),
    .data_out(data_out),
    .data_ready(data_ready),
    .user_interrupt(user_interrupt)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {invalid, overflow, zero, result}.
  function automatic logic [34:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [1:0] op);
    int ea, eb, e;
    longint ma, mb, big, sml, s;
    bit sa, sb, so, na, nb, ia, ib, za, zb, inv, ovf;
    logic [31:0] r;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    sa = a[31];
    sb = b[31] ^ (op == 2'b01);
    za = ea == 0;
    zb = eb == 0;
    na = ea == 255 && a[22:0] != 0;
    nb = eb == 255 && b[22:0] != 0;
    ia = ea == 255 && a[22:0] == 0;
    ib = eb == 255 && b[22:0] == 0;
    ma = za ? 0 : (longint'(1) << 23) + longint'(a[22:0]);
    mb = zb ? 0 : (longint'(1) << 23) + longint'(b[22:0]);
    inv = 0;
    ovf = 0;
    if (op == 2'b10) begin
      so = a[31] ^ b[31];
      if (na || nb || (ia && zb) || (za && ib)) begin
        r = 32'h7FC00000; inv = 1;
      end else if (ia || ib) begin
        r = {so, 8'hFF, 23'h0};
      end else if (za || zb) begin
        r = {so, 31'h0};
      end else begin
        s = ma * mb;
        e = ea + eb - 127;
        if (s >= (longint'(1) << 47)) begin s = s >> 1; e++; end
        s = s >> 23;
        if (e >= 255) begin r = {so, 8'hFF, 23'h0}; ovf = 1; end
        else if (e <= 0) r = {so, 31'h0};
        else r = {so, 8'(e), 23'(s)};
      end
    end else begin
      if (na || nb || (ia && ib && sa != sb)) begin
        r = 32'h7FC00000; inv = 1;
      end else if (ia) begin
        r = {sa, 8'hFF, 23'h0};
      end else if (ib) begin
        r = {sb, 8'hFF, 23'h0};
      end else begin
        if (ea > eb || (ea == eb && ma >= mb)) begin
          big = ma; e = ea; so = sa; sml = mb >> (ea - eb);
        end else begin
          big = mb; e = eb; so = sb; sml = ma >> (eb - ea);
        end
        s = (sa != sb) ? big - sml : big + sml;
        if (s == 0) r = 32'h0;
        else begin
          while (s >= (longint'(1) << 24)) begin s = s >> 1; e++; end
          while (s < (longint'(1) << 23)) begin s = s << 1; e--; end
          if (e >= 255) begin r = {so, 8'hFF, 23'h0}; ovf = 1; end
          else if (e <= 0) r = 32'h0;
          else r = {so, 8'(e), 23'(s)};
        end
      end
    end
    return {inv, ovf, r[30:0] == 0, r};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [7:0]  e;
    logic [22:0] m;
    int c;
    c = int'($urandom_range(0, 11));
    m = 23'($urandom);
    case (c)
      0: begin e = 8'h00; m = '0; end
      1: begin e = 8'hFF; m = '0; end
      2: begin e = 8'hFF; m = m | 23'd1; end
      3: begin e = 8'h00; m = m | 23'd1; end
      4: e = 8'($urandom_range(230, 254));
      5: e = 8'($urandom_range(1, 12));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, m};
  endfunction

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; data_in = d; data_write_n = 2'b10;
    @(negedge clk);
    data_write_n = 2'b11;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; data_read_n = 2'b00;
    #1 d = data_out;
    @(negedge clk);
    data_read_n = 2'b11;
  endtask

  task automatic peek(input logic [5:0] a, output logic [31:0] d);
    address = a;
    #1 d = data_out;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!uo_out[1] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] op, input string tag);
    logic [34:0] m;
    logic [31:0] r;
    int cyc;
    m = model(a, b, op);
    wr(6'h00, a);
    wr(6'h04, b);
    wr(6'h08, {30'b0, op});
    check({tag, " busy"}, 32'(uo_out[0]), 32'd1);
    wait_done(cyc);
    check({tag, " lat"}, cyc, (op == 2'b10) ? K + 1 : 2);
    rd(6'h10, r);
    check({tag, " status"}, r, {27'b0, m[32], m[33], m[34], 2'b10});
    rd(6'h0C, r);
    check({tag, " result"}, r, m[31:0]);
    last_res = m[31:0];
  endtask

  initial begin
    logic [31:0] r, a, b;
    logic [34:0] m;
    logic [1:0] op;
    int cyc;
    ui_in = '0; address = '0; data_in = '0;
    data_write_n = 2'b11; data_read_n = 2'b11;
    #12;
    check("rst uo_out", 32'(uo_out), 32'd0);
    check("rst irq", 32'(user_interrupt), 32'd0);
    check("data_ready", 32'(data_ready), 32'd1);
    peek(6'h0C, r); check("rst result", r, 32'd0);
    peek(6'h10, r); check("rst status", r, 32'd0);
    peek(6'h08, r); check("rst ctrl", r, 32'd0);
    rst_n = 1'b1;

    run(32'h3FC00000, 32'h40100000, 2'b00, "add_plan");
    peek(6'h0C, r); check("add_plan const", r, 32'h40700000);

    wr(6'h00, 32'h40400000);
    wr(6'h04, 32'hC0000000);
    wr(6'h08, 32'h2);
    wr(6'h00, 32'h0);
    wait_done(cyc);
    check("mul_plan lat", cyc + 2, K + 1);
    peek(6'h00, r); check("mul_plan a_kept", r, 32'h40400000);
    rd(6'h0C, r); check("mul_plan result", r, 32'hC0C00000);
    last_res = r;

    run(32'h3F800000, 32'h3F800000, 2'b01, "sub_zero");
    peek(6'h0C, r); check("sub_zero const", r, 32'h00000000);
    run(32'h7F000000, 32'h7F000000, 2'b10, "mul_ovf");
    peek(6'h0C, r); check("mul_ovf const", r, 32'h7F800000);
    run(32'h7F800000, 32'h00000000, 2'b10, "inf_x_0");
    peek(6'h0C, r); check("inf_x_0 const", r, 32'h7FC00000);
    run(32'h7FC00001, 32'h3F800000, 2'b00, "nan_add");
    peek(6'h0C, r); check("nan_add const", r, 32'h7FC00000);

    wr(6'h08, 32'h7);
    check("rsv no_start", 32'(uo_out), 32'd0);
    peek(6'h08, r); check("rsv irq_en", r, 32'h4);

    m = model(32'h40000000, 32'h3F800000, 2'b00);
    wr(6'h00, 32'h40000000);
    wr(6'h04, 32'h3F800000);
    wr(6'h08, 32'h4);
    @(negedge clk);
    check("irq pre", 32'(user_interrupt), 32'd0);
    @(negedge clk);
    check("irq done", 32'(uo_out[1]), 32'd1);
    check("irq rise", 32'(user_interrupt), 32'd1);
    rd(6'h0C, r); check("irq result", r, m[31:0]);
    check("irq done_clr", 32'(uo_out[1]), 32'd0);
    check("irq fall", 32'(user_interrupt), 32'd0);
    last_res = m[31:0];

    m = model(32'h3F800000, 32'h3E800000, 2'b01);
    wr(6'h00, 32'h3F800000);
    wr(6'h04, 32'h3E800000);
    wr(6'h08, 32'h1);
    @(negedge clk);
    address = 6'h0C; data_read_n = 2'b00;
    #1 r = data_out;
    check("race old_result", r, last_res);
    @(negedge clk);
    data_read_n = 2'b11;
    check("race done_set", 32'(uo_out[1]), 32'd1);
    peek(6'h0C, r); check("race new_result", r, m[31:0]);
    rd(6'h0C, r);

    wr(6'h00, 32'h40400000);
    wr(6'h04, 32'h40400000);
    wr(6'h08, 32'h2);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst uo_out", 32'(uo_out), 32'd0);
    check("arst irq", 32'(user_interrupt), 32'd0);
    peek(6'h0C, r); check("arst result", r, 32'd0);
    peek(6'h00, r); check("arst a", r, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(32'h40000000, 32'h3F800000, 2'b00, "post_rst");
    peek(6'h0C, r); check("post_rst const", r, 32'h40400000);

    for (int i = 0; i < 60; i++) begin
      a = rnd_fp();
      b = ($urandom_range(0, 4) == 0)
        ? (a ^ {1'($urandom), 31'b0}) : rnd_fp();
      op = 2'($urandom_range(0, 2));
      run(a, b, op, $sformatf("rnd%0d op%0d", i, op));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
